// File: rtl/deskew_pkg.sv
// Shared deskew definitions: address width helper and the delay clamp used by
// every deskew stage that turns a signed correction into a buffer delay.
package deskew_pkg;

   localparam int CLAMP_W = 32;

   typedef struct packed {
      logic [CLAMP_W-1:0] delay;
      logic               sat;
   } clamp_t;

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Clamp a signed delay request into [0, max_delay]; sat flags either clamp.
   function automatic clamp_t clamp_delay(input logic signed [CLAMP_W-1:0] sum,
                                          input logic signed [CLAMP_W-1:0] max_delay);
      clamp_t r;
      r.delay = sum;
      r.sat   = 1'b0;
      if (sum < 0) begin
         r.delay = '0;
         r.sat   = 1'b1;
      end else if (sum > max_delay) begin
         r.delay = max_delay;
         r.sat   = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/deskew_delay_line_ram.sv
// Sample store for the deskew delay line: one synchronous write port and one
// combinational read port so it maps onto distributed RAM.
module deskew_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/deskew_delay_line.sv
// Variable delay buffer: base delay plus a signed, clamped correction, applied
// as a count of valid samples through a circular buffer.
module deskew_delay_line
   import deskew_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CORR_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int BASE_DELAY = 16,
   localparam int ADDR_W    = addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CORR_WIDTH-1:0] corr_in,
   input  logic                  corr_load,
   input  logic                  din_valid,
   input  logic [WIDTH-1:0]      din,
   output logic                  dout_valid,
   output logic [WIDTH-1:0]      dout,
   output logic [ADDR_W-1:0]     delay_cur,
   output logic                  sat
);

   // Two guard bits over the wider operand keep the sum from ever wrapping.
   localparam int SUM_W = (CORR_WIDTH + 2 > ADDR_W + 2) ? CORR_WIDTH + 2 : ADDR_W + 2;

   logic signed [SUM_W-1:0] corr_sum;
   clamp_t                  clamp_res;

   logic [ADDR_W-1:0] delay_q, delay_d;
   logic              sat_q, sat_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] fill_q, fill_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;

   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;

   deskew_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (din_valid & ~rst),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      corr_sum  = {{(SUM_W-CORR_WIDTH){corr_in[CORR_WIDTH-1]}}, corr_in} + SUM_W'(BASE_DELAY);
      clamp_res = clamp_delay(CLAMP_W'(corr_sum), CLAMP_W'(DEPTH - 1));
      delay_d   = corr_load ? ADDR_W'(clamp_res.delay) : delay_q;
      sat_d     = corr_load ? clamp_res.sat : sat_q;
   end

   // Read lands on the entry written d samples ago; it precedes this cycle's write.
   assign rd_addr = wr_ptr_q - delay_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      fill_d       = fill_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (din_valid) begin
         wr_ptr_d     = wr_ptr_q + 1'b1;
         fill_d       = (fill_q == ADDR_W'(DEPTH - 1)) ? fill_q : fill_q + 1'b1;
         dout_d       = (delay_q == '0) ? din : rd_data;
         dout_valid_d = (fill_q >= delay_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         delay_q      <= ADDR_W'(BASE_DELAY);
         sat_q        <= 1'b0;
         wr_ptr_q     <= '0;
         fill_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         delay_q      <= delay_d;
         sat_q        <= sat_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_q       <= fill_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout       = dout_q;
   assign delay_cur  = delay_q;
   assign sat        = sat_q;

endmodule
